// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - DEFAULT_WIDTH : default operand/result width in bits
//   - state_e       : controller state encoding (IDLE / RUN / DONE)
//   - sub_overflow  : two's-complement overflow rule for a - b
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow of a - b: operands of opposite sign and a result whose
    // sign differs from the minuend.
    function automatic logic sub_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb
    );
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// -----------------------------------------------------------------------------
// FullSubtractor
// One-bit combinational full subtractor computing a - b - borrow_in.
// Ports:
//   a_i      : minuend bit
//   b_i      : subtrahend bit
//   borrow_i : borrow from the previous (less significant) bit
//   diff_o   : difference bit
//   borrow_o : borrow into the next (more significant) bit
// -----------------------------------------------------------------------------
module FullSubtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_i,
    output logic diff_o,
    output logic borrow_o
);

    // Borrow is generated when a=0,b=1, and propagated when a==b.
    always_comb begin
        diff_o   = a_i ^ b_i ^ borrow_i;
        borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor computing a - b modulo 2^WIDTH, one bit per clock,
// LSB first, with valid/ready handshakes on both the operand and result side.
// An operation takes WIDTH cycles from the accepting edge to valid_o.
// Ports:
//   clk_i    : clock, all state updates on the rising edge
//   rst_n_i  : synchronous active-low reset
//   valid_i  : operands a_i/b_i presented
//   ready_o  : block idle and able to accept operands
//   a_i      : minuend (WIDTH bits)
//   b_i      : subtrahend (WIDTH bits)
//   valid_o  : result valid (held until ready_i)
//   ready_i  : consumer takes the result
//   diff_o   : a - b modulo 2^WIDTH
//   borrow_o : unsigned a < b
//   ovf_o    : two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic               a_msb_q,  a_msb_d;
    logic               b_msb_q,  b_msb_d;
    logic               br_q,     br_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q,    ovf_d;
    logic               ready_q,  ready_d;
    logic               valid_q,  valid_d;

    logic               fs_diff_s;
    logic               fs_borrow_s;

    FullSubtractor u_full_sub (
        .a_i      (a_q[0]),
        .b_i      (b_q[0]),
        .borrow_i (br_q),
        .diff_o   (fs_diff_s),
        .borrow_o (fs_borrow_s)
    );

    // Next-state, datapath and handshake-flag computation.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    // Operand sign bits are shifted out during RUN, so keep
                    // them aside for the overflow decision.
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
                    br_d    = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                // Result enters at the MSB so that after WIDTH shifts bit 0
                // has reached position 0.
                diff_d = {fs_diff_s, diff_q[WIDTH-1:1]};
                br_d   = fs_borrow_s;
                if (cnt_q == LAST_BIT) begin
                    // Counter is left at its last value rather than wrapped.
                    state_d  = DONE;
                    borrow_d = fs_borrow_s;
                    ovf_d    = sub_overflow(a_msb_q, b_msb_q, fs_diff_s);
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = RUN;
                end
            end

            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered alongside the state they decode.
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            br_q     <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=16). Directed vectors,
// backpressure, busy-ignore, mid-run reset and randomized operands compared
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 16;

    logic         clk_i;
    logic         rst_n_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] diff_o;
    logic         borrow_o;
    logic         ovf_o;

    int pass_cnt;
    int chk_cnt;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .diff_o   (diff_o),
        .borrow_o (borrow_o),
        .ovf_o    (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: {ovf, borrow, diff} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        int         sa;
        int         sb;
        int         sd;
        logic [W-1:0] d;
        logic       br;
        logic       ov;
        d  = a - b;
        br = (a < b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb;
        ov = (sd > 32767) || (sd < -32768);
        return {ov, br, d};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present operands for one accepting edge (waits for ready_o, bounded).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (ready_o !== 1'b1) begin
            chk_cnt++;
            $display("FAIL issue_timeout ready_o=%b required 1", ready_o);
        end
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        a_i     = W'($urandom);
        b_i     = W'($urandom);
    endtask

    // Count edges until valid_o, bounded; returns -1 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        while (valid_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (valid_o !== 1'b1) n = -1;
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b1;
        a_i     = 16'h1234;
        b_i     = 16'h0001;
        tick();
        tick();
        chk_cnt++; if (ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", ready_o); else pass_cnt++;
        chk_cnt++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_o); else pass_cnt++;
        chk_cnt++; if (diff_o !== 16'h0000) $display("FAIL reset_diff got %h want 0000", diff_o); else pass_cnt++;
        chk_cnt++; if (borrow_o !== 1'b0) $display("FAIL reset_borrow got %b want 0", borrow_o); else pass_cnt++;
        chk_cnt++; if (ovf_o !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf_o); else pass_cnt++;
        rst_n_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic [W-1:0] vd [4];
        logic         vbr[4];
        logic         vov[4];
        int n;
        va[0] = 16'h0005; vb[0] = 16'h0003; vd[0] = 16'h0002; vbr[0] = 1'b0; vov[0] = 1'b0;
        va[1] = 16'h0003; vb[1] = 16'h0005; vd[1] = 16'hFFFE; vbr[1] = 1'b1; vov[1] = 1'b0;
        va[2] = 16'h8000; vb[2] = 16'h0001; vd[2] = 16'h7FFF; vbr[2] = 1'b0; vov[2] = 1'b1;
        va[3] = 16'h7FFF; vb[3] = 16'hFFFF; vd[3] = 16'h8000; vbr[3] = 1'b1; vov[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i]);
            chk_cnt++; if (ready_o !== 1'b0) $display("FAIL dir%0d_busy_ready got %b want 0", i, ready_o); else pass_cnt++;
            wait_valid(n);
            chk_cnt++; if (n !== W) $display("FAIL dir%0d_latency got %0d want %0d", i, n, W); else pass_cnt++;
            chk_cnt++; if (diff_o !== vd[i]) $display("FAIL dir%0d_diff got %h want %h", i, diff_o, vd[i]); else pass_cnt++;
            chk_cnt++; if (borrow_o !== vbr[i]) $display("FAIL dir%0d_borrow got %b want %b", i, borrow_o, vbr[i]); else pass_cnt++;
            chk_cnt++; if (ovf_o !== vov[i]) $display("FAIL dir%0d_ovf got %b want %b", i, ovf_o, vov[i]); else pass_cnt++;
            release_result();
            chk_cnt++; if (ready_o !== 1'b1 || valid_o !== 1'b0)
                $display("FAIL dir%0d_release ready/valid got %b/%b want 1/0", i, ready_o, valid_o); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] exp;
        int n;
        exp = ref_sub(16'h0003, 16'h0005);
        issue(16'h0003, 16'h0005);
        wait_valid(n);
        chk_cnt++; if (n !== W) $display("FAIL bp_latency got %0d want %0d", n, W); else pass_cnt++;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_cnt++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || diff_o !== exp[W-1:0] ||
                borrow_o !== exp[W] || ovf_o !== exp[W+1])
                $display("FAIL bp_hold%0d got v=%b r=%b d=%h br=%b ov=%b want v=1 r=0 d=%h br=%b ov=%b",
                         k, valid_o, ready_o, diff_o, borrow_o, ovf_o, exp[W-1:0], exp[W], exp[W+1]);
            else pass_cnt++;
        end
        // Release together with a new valid_i: must not be accepted on this edge.
        ready_i = 1'b1;
        valid_i = 1'b1;
        a_i     = 16'h1111;
        b_i     = 16'h0101;
        chk_cnt++; if (ready_o !== 1'b0) $display("FAIL bp_ready_before_edge got %b want 0", ready_o); else pass_cnt++;
        tick();
        ready_i = 1'b0;
        valid_i = 1'b0;
        chk_cnt++; if (ready_o !== 1'b1 || valid_o !== 1'b0)
            $display("FAIL bp_release ready/valid got %b/%b want 1/0", ready_o, valid_o); else pass_cnt++;
        chk_cnt++; if (diff_o !== exp[W-1:0] || borrow_o !== exp[W] || ovf_o !== exp[W+1])
            $display("FAIL bp_retain got d=%h br=%b ov=%b want d=%h br=%b ov=%b",
                     diff_o, borrow_o, ovf_o, exp[W-1:0], exp[W], exp[W+1]); else pass_cnt++;
        tick();
        chk_cnt++; if (ready_o !== 1'b1) $display("FAIL bp_no_accept ready got %b want 1", ready_o); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        logic [W+1:0] exp;
        int n;
        exp = ref_sub(16'h4321, 16'h1234);
        issue(16'h4321, 16'h1234);
        valid_i = 1'b1;
        a_i     = 16'h0001;
        b_i     = 16'hFFFF;
        for (int k = 0; k < 3; k++) tick();
        valid_i = 1'b0;
        wait_valid(n);
        if (n >= 0) n = n + 3;
        chk_cnt++; if (n !== W) $display("FAIL busy_latency got %0d want %0d", n, W); else pass_cnt++;
        chk_cnt++; if (diff_o !== exp[W-1:0] || borrow_o !== exp[W] || ovf_o !== exp[W+1])
            $display("FAIL busy_result got d=%h br=%b ov=%b want d=%h br=%b ov=%b",
                     diff_o, borrow_o, ovf_o, exp[W-1:0], exp[W], exp[W+1]); else pass_cnt++;
        release_result();
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W+1:0] exp;
        int n;
        int dly;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i % 5 == 0) b = a;
            exp = ref_sub(a, b);
            issue(a, b);
            wait_valid(n);
            chk_cnt++; if (n !== W) $display("FAIL rnd%0d_latency got %0d want %0d", i, n, W); else pass_cnt++;
            chk_cnt++; if (diff_o !== exp[W-1:0] || borrow_o !== exp[W] || ovf_o !== exp[W+1])
                $display("FAIL rnd%0d a=%h b=%h got d=%h br=%b ov=%b want d=%h br=%b ov=%b", i, a, b,
                         diff_o, borrow_o, ovf_o, exp[W-1:0], exp[W], exp[W+1]); else pass_cnt++;
            dly = int'($urandom_range(0, 3));
            for (int k = 0; k < dly; k++) tick();
            chk_cnt++; if (valid_o !== 1'b1) $display("FAIL rnd%0d_hold valid got %b want 1", i, valid_o); else pass_cnt++;
            release_result();
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        issue(16'hBEEF, 16'h1357);
        for (int k = 0; k < 7; k++) tick();
        rst_n_i = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b1;
        tick();
        chk_cnt++; if (ready_o !== 1'b1 || valid_o !== 1'b0)
            $display("FAIL midrst_state ready/valid got %b/%b want 1/0", ready_o, valid_o); else pass_cnt++;
        chk_cnt++; if (diff_o !== 16'h0000 || borrow_o !== 1'b0 || ovf_o !== 1'b0)
            $display("FAIL midrst_outputs got d=%h br=%b ov=%b want 0000/0/0", diff_o, borrow_o, ovf_o); else pass_cnt++;
        rst_n_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        tick();
        chk_cnt++; if (ready_o !== 1'b1) $display("FAIL midrst_idle ready got %b want 1", ready_o); else pass_cnt++;
        issue(16'd9, 16'd4);
        wait_valid(n);
        chk_cnt++; if (n !== W) $display("FAIL midrst_latency got %0d want %0d", n, W); else pass_cnt++;
        chk_cnt++; if (diff_o !== 16'h0005 || borrow_o !== 1'b0 || ovf_o !== 1'b0)
            $display("FAIL midrst_9m4 got d=%h br=%b ov=%b want 0005/0/0", diff_o, borrow_o, ovf_o); else pass_cnt++;
        release_result();
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rst_n_i  = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        a_i      = 16'h0000;
        b_i      = 16'h0000;
        test_reset();
        test_directed();
        test_backpressure();
        test_busy_ignore();
        test_random();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand/result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port valid_i, input, 1 bit: operands presented.
REQ-005 The block SHALL have port ready_o, output, 1 bit: block accepts operands.
REQ-006 The block SHALL have port a_i, input, WIDTH bits: minuend.
REQ-007 The block SHALL have port b_i, input, WIDTH bits: subtrahend.
REQ-008 The block SHALL have port valid_o, output, 1 bit: result valid.
REQ-009 The block SHALL have port ready_i, input, 1 bit: consumer takes result.
REQ-010 The block SHALL have port diff_o, output, WIDTH bits: a - b modulo 2^WIDTH.
REQ-011 The block SHALL have port borrow_o, output, 1 bit: unsigned a < b.
REQ-012 The block SHALL have port ovf_o, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 ready_o SHALL be 1 only in IDLE, and valid_o SHALL be 1 only in DONE.
REQ-015 In IDLE, valid_i=1 on an edge SHALL capture a_i and b_i into shift registers, clear the borrow flop and the bit counter, and enter RUN.
REQ-016 In IDLE with valid_i=0, the state and all result outputs SHALL be held.
REQ-017 In RUN, each edge SHALL process one bit, LSB first, as d = a ^ b ^ br and br_next = (~a & b) | (~(a ^ b) & br).
REQ-018 In RUN, each result bit SHALL be shifted into the diff register from the MSB end, and the counter SHALL be incremented.
REQ-019 On the edge that processes bit WIDTH-1, the FSM SHALL enter DONE.
REQ-020 valid_o SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-021 In RUN, changes on a_i, b_i and valid_i SHALL be ignored.
REQ-022 In DONE, diff_o, borrow_o and ovf_o SHALL be stable.
REQ-023 borrow_o SHALL equal the final borrow.
REQ-024 ovf_o SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
REQ-025 In DONE, ready_i=1 SHALL return the FSM to IDLE on the next edge; ready_i=0 SHALL hold DONE indefinitely (backpressure).
REQ-026 On return to IDLE, diff_o, borrow_o and ovf_o SHALL retain their values until the next accept.
REQ-027 A new valid_i coinciding with the DONE->IDLE edge SHALL NOT be accepted; acceptance requires ready_o=1 in that cycle, so the minimum issue interval is WIDTH+2 cycles.
REQ-028 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-029 rst_n_i=0 on an edge SHALL force IDLE from any state, including mid-RUN, and abandon any partial result.
REQ-030 During reset, ready_o SHALL be 1 and valid_o 0 after the edge.
REQ-031 During reset, diff_o, borrow_o, ovf_o, the operand registers, the borrow flop and the counter SHALL be cleared to 0.
REQ-032 Reset SHALL take priority over valid_i and ready_i in the same cycle.

Structure
REQ-033 A shared package serial_sub_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width constant 16.
REQ-034 The per-bit arithmetic SHALL live in one combinational sub-module, FullSubtractor (a_i, b_i, borrow_i, diff_o, borrow_o), instantiated once.
REQ-035 The FSM, shift registers and counter SHALL reside in serial_subtractor.

Verification
REQ-036 The bench SHALL check: a=5, b=3, WIDTH=16 -> valid_o at cycle 16 after accept, diff=0x0002, borrow=0, ovf=0.
REQ-037 The bench SHALL check: a=3, b=5 -> diff=0xFFFE, borrow=1, ovf=0.
REQ-038 The bench SHALL check: a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1; and a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1.
REQ-039 The bench SHALL check backpressure: ready_i held 0 for 10 cycles in DONE -> valid_o and results stable throughout, and ready_o stays 0 until one edge after ready_i=1.
REQ-040 The bench SHALL check busy and reset behaviour: valid_i pulsed with new operands mid-RUN -> ignored, result matches the first operands; rst_n_i=0 at bit 7 -> IDLE next edge, outputs 0, and a subsequent 9-4 gives diff=0x0005.
